// File: rtl/phys_reg_map_table_ctrl.sv
// phys_reg_map_table_ctrl
// Front-end sequencer for the single-op physical register map table. In IDLE it
// arbitrates mispredict recovery, checkpoint saves and renames onto the map table.
// It also forwards correct-branch checkpoint releases alongside those grants.
// On a mispredict with no usable checkpoint it enters WALK. WALK steps back through
// the ROB from youngest to oldest and issues one revert per cycle until it reaches
// the mispredicted branch.
module phys_reg_map_table_ctrl #(
    parameter int ARCH_W = 5,
    parameter int PHYS_W = 6,
    parameter int ROB_W  = 4,
    parameter int COL_W  = 2
) (
    input  logic              clk_i,
    input  logic              nrst_i,

    // dispatch rename
    input  logic              ren_valid_i,
    output logic              ren_ready_o,
    input  logic [ARCH_W-1:0] ren_arch_i,
    input  logic [PHYS_W-1:0] ren_phys_i,

    // dispatch checkpoint save
    input  logic              save_valid_i,
    output logic              save_ready_o,
    input  logic [ROB_W-1:0]  save_rob_i,

    // branch resolution
    input  logic              br_valid_i,
    output logic              br_ready_o,
    input  logic              br_mispred_i,
    input  logic [ROB_W-1:0]  br_rob_i,
    input  logic [COL_W-1:0]  br_col_i,
    input  logic              br_has_ckpt_i,

    // ROB view
    input  logic [ROB_W-1:0]  rob_tail_i,
    output logic [ROB_W-1:0]  walk_idx_o,
    input  logic              walk_wr_reg_i,
    input  logic [ARCH_W-1:0] walk_arch_i,
    input  logic [PHYS_W-1:0] walk_safe_i,
    input  logic [PHYS_W-1:0] walk_spec_i,

    // map table command port
    output logic              mt_rename_valid_o,
    output logic [ARCH_W-1:0] mt_rename_arch_o,
    output logic [PHYS_W-1:0] mt_rename_phys_o,
    output logic              mt_save_valid_o,
    output logic [ROB_W-1:0]  mt_save_rob_o,
    output logic              mt_restore_valid_o,
    output logic              mt_restore_failed_o,
    output logic [ROB_W-1:0]  mt_restore_rob_o,
    output logic [COL_W-1:0]  mt_restore_col_o,
    input  logic              mt_restore_ok_i,
    output logic              mt_revert_valid_o,
    output logic [ARCH_W-1:0] mt_revert_arch_o,
    output logic [PHYS_W-1:0] mt_revert_safe_o,
    output logic [PHYS_W-1:0] mt_revert_spec_o,

    // status
    output logic [COL_W:0]    ckpt_count_o,
    output logic              recovering_o,
    output logic              recover_done_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WALK = 1'b1
    } state_e;

    // Highest number of checkpoints that may be live at once.
    localparam logic [COL_W:0] MAX_CKPT = (COL_W+1)'((1 << COL_W) - 1);
    localparam logic [COL_W:0] CNT_ONE  = (COL_W+1)'(1);
    localparam logic [ROB_W-1:0] ROB_ONE = ROB_W'(1);

    state_e           state_q, state_d;
    logic [ROB_W-1:0] ptr_q, ptr_d;
    logic [ROB_W-1:0] target_q, target_d;
    logic [COL_W:0]   ckpt_count_q, ckpt_count_d;
    logic             recover_done_q, recover_done_d;

    logic             mispred;
    logic             save_grant;
    logic             ren_grant;
    logic             ckpt_release;

    // Payload fields follow their sources. Only the valid strobes are qualified.
    assign mt_rename_arch_o = ren_arch_i;
    assign mt_rename_phys_o = ren_phys_i;
    assign mt_save_rob_o    = save_rob_i;
    assign mt_restore_rob_o = br_rob_i;
    assign mt_restore_col_o = br_col_i;
    assign mt_revert_arch_o = walk_arch_i;
    assign mt_revert_safe_o = walk_safe_i;
    assign mt_revert_spec_o = walk_spec_i;

    assign walk_idx_o     = ptr_q;
    assign ckpt_count_o   = ckpt_count_q;
    assign recovering_o   = (state_q == ST_WALK);
    assign recover_done_o = recover_done_q;

    assign mispred = br_valid_i & br_mispred_i;

    // Arbitration, map-table strobes and next-state selection.
    always_comb begin
        state_d             = state_q;
        ptr_d               = ptr_q;
        target_d            = target_q;
        ckpt_count_d        = ckpt_count_q;
        recover_done_d      = 1'b0;
        ren_ready_o         = 1'b0;
        save_ready_o        = 1'b0;
        br_ready_o          = 1'b0;
        mt_rename_valid_o   = 1'b0;
        mt_save_valid_o     = 1'b0;
        mt_restore_valid_o  = 1'b0;
        mt_restore_failed_o = 1'b0;
        mt_revert_valid_o   = 1'b0;
        save_grant          = 1'b0;
        ren_grant           = 1'b0;
        ckpt_release        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A resolving branch is always accepted in IDLE.
                // Mispredicts get the port exclusively.
                br_ready_o = 1'b1;
                if (mispred) begin
                    if (br_has_ckpt_i) begin
                        mt_restore_valid_o  = 1'b1;
                        mt_restore_failed_o = 1'b1;
                    end
                    if (br_has_ckpt_i && mt_restore_ok_i) begin
                        // A checkpoint restore discards every younger checkpoint.
                        ckpt_count_d   = '0;
                        recover_done_d = 1'b1;
                    end else begin
                        state_d  = ST_WALK;
                        ptr_d    = rob_tail_i - ROB_ONE;
                        target_d = br_rob_i;
                    end
                end else begin
                    save_ready_o = (ckpt_count_q < MAX_CKPT);
                    ren_ready_o  = ~save_valid_i;
                    save_grant   = save_valid_i & save_ready_o;
                    ren_grant    = ren_valid_i & ren_ready_o;
                    mt_save_valid_o   = save_grant;
                    mt_rename_valid_o = ren_grant;

                    // A correct branch frees its checkpoint. This uses the restore
                    // lane, so it can share the cycle with a save or a rename.
                    if (br_valid_i && br_has_ckpt_i) begin
                        mt_restore_valid_o = 1'b1;
                        ckpt_release = mt_restore_ok_i & (ckpt_count_q != '0);
                    end

                    if (save_grant && !ckpt_release) begin
                        ckpt_count_d = ckpt_count_q + CNT_ONE;
                    end else if (!save_grant && ckpt_release) begin
                        ckpt_count_d = ckpt_count_q - CNT_ONE;
                    end
                end
            end

            ST_WALK: begin
                // The branch entry itself stays mapped. Reaching it ends the walk.
                if (ptr_q == target_q) begin
                    state_d        = ST_IDLE;
                    ckpt_count_d   = '0;
                    recover_done_d = 1'b1;
                end else begin
                    mt_revert_valid_o = walk_wr_reg_i;
                    ptr_d             = ptr_q - ROB_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, walk pointers, checkpoint count and done pulse, with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state_q        <= ST_IDLE;
            ptr_q          <= '0;
            target_q       <= '0;
            ckpt_count_q   <= '0;
            recover_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            target_q       <= target_d;
            ckpt_count_q   <= ckpt_count_d;
            recover_done_q <= recover_done_d;
        end
    end

endmodule

// File: tb/tb_phys_reg_map_table_ctrl.sv
// Directed bench for phys_reg_map_table_ctrl: a per-cycle vector table for the
// IDLE arbitration and checkpoint counting, plus hand-written ROB walk sequences.
module tb_phys_reg_map_table_ctrl;

    logic       clk_i = 1'b0;
    logic       nrst_i;
    logic       ren_valid_i, ren_ready_o;
    logic [4:0] ren_arch_i;
    logic [5:0] ren_phys_i;
    logic       save_valid_i, save_ready_o;
    logic [3:0] save_rob_i;
    logic       br_valid_i, br_ready_o, br_mispred_i, br_has_ckpt_i;
    logic [3:0] br_rob_i;
    logic [1:0] br_col_i;
    logic [3:0] rob_tail_i, walk_idx_o;
    logic       walk_wr_reg_i;
    logic [4:0] walk_arch_i;
    logic [5:0] walk_safe_i, walk_spec_i;
    logic       mt_rename_valid_o;
    logic [4:0] mt_rename_arch_o;
    logic [5:0] mt_rename_phys_o;
    logic       mt_save_valid_o;
    logic [3:0] mt_save_rob_o;
    logic       mt_restore_valid_o, mt_restore_failed_o;
    logic [3:0] mt_restore_rob_o;
    logic [1:0] mt_restore_col_o;
    logic       mt_restore_ok_i;
    logic       mt_revert_valid_o;
    logic [4:0] mt_revert_arch_o;
    logic [5:0] mt_revert_safe_o, mt_revert_spec_o;
    logic [2:0] ckpt_count_o;
    logic       recovering_o, recover_done_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    phys_reg_map_table_ctrl dut (
        .clk_i(clk_i), .nrst_i(nrst_i),
        .ren_valid_i(ren_valid_i), .ren_ready_o(ren_ready_o),
        .ren_arch_i(ren_arch_i), .ren_phys_i(ren_phys_i),
        .save_valid_i(save_valid_i), .save_ready_o(save_ready_o), .save_rob_i(save_rob_i),
        .br_valid_i(br_valid_i), .br_ready_o(br_ready_o), .br_mispred_i(br_mispred_i),
        .br_rob_i(br_rob_i), .br_col_i(br_col_i), .br_has_ckpt_i(br_has_ckpt_i),
        .rob_tail_i(rob_tail_i), .walk_idx_o(walk_idx_o), .walk_wr_reg_i(walk_wr_reg_i),
        .walk_arch_i(walk_arch_i), .walk_safe_i(walk_safe_i), .walk_spec_i(walk_spec_i),
        .mt_rename_valid_o(mt_rename_valid_o), .mt_rename_arch_o(mt_rename_arch_o),
        .mt_rename_phys_o(mt_rename_phys_o),
        .mt_save_valid_o(mt_save_valid_o), .mt_save_rob_o(mt_save_rob_o),
        .mt_restore_valid_o(mt_restore_valid_o), .mt_restore_failed_o(mt_restore_failed_o),
        .mt_restore_rob_o(mt_restore_rob_o), .mt_restore_col_o(mt_restore_col_o),
        .mt_restore_ok_i(mt_restore_ok_i),
        .mt_revert_valid_o(mt_revert_valid_o), .mt_revert_arch_o(mt_revert_arch_o),
        .mt_revert_safe_o(mt_revert_safe_o), .mt_revert_spec_o(mt_revert_spec_o),
        .ckpt_count_o(ckpt_count_o), .recovering_o(recovering_o),
        .recover_done_o(recover_done_o)
    );

    // One IDLE cycle: inputs and the outputs expected before the clock edge.
    // rdy = {ren_ready, save_ready, br_ready}
    // mt  = {rename_v, save_v, restore_v, restore_failed, revert_v}
    // st  = {recovering, recover_done}
    typedef struct {
        logic       ren_v;
        logic       save_v;
        logic       br_v;
        logic       mis;
        logic       has;
        logic       ok;
        logic [2:0] rdy;
        logic [4:0] mt;
        logic [1:0] st;
        logic [2:0] cnt;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] out_pack();
        return {ren_ready_o, save_ready_o, br_ready_o,
                mt_rename_valid_o, mt_save_valid_o, mt_restore_valid_o,
                mt_restore_failed_o, mt_revert_valid_o,
                recovering_o, recover_done_o, ckpt_count_o};
    endfunction

    task automatic idle_inputs();
        ren_valid_i = 0; save_valid_i = 0; br_valid_i = 0; br_mispred_i = 0;
        br_has_ckpt_i = 0; mt_restore_ok_i = 0; walk_wr_reg_i = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Mispredict with no usable checkpoint, then follow the ROB walk.
    // wr_mode 0: every entry writes a register; 1: only odd indices do.
    // rst_at >= 0 pulls reset low during that walk step.
    task automatic do_walk(input string tag, input logic [3:0] tail, input logic [3:0] brrob,
                           input logic has, input logic wr_mode, input int rst_at);
        logic [3:0] n;
        logic [3:0] idx;
        logic       wr;
        logic       exp_rv;
        n = tail - 4'd1 - brrob;
        rob_tail_i = tail; br_rob_i = brrob; br_col_i = 2'd2;
        br_valid_i = 1; br_mispred_i = 1; br_has_ckpt_i = has; mt_restore_ok_i = 0;
        save_valid_i = 1; ren_valid_i = 1;
        #2;
        chk({tag, "_launch"}, {29'd0, br_ready_o, save_ready_o, ren_ready_o}, 32'b100);
        chk({tag, "_launch_rs"}, {30'd0, mt_restore_valid_o, mt_restore_failed_o}, {30'd0, has, has});
        next_cycle();
        br_valid_i = 0; br_mispred_i = 0;
        for (int k = 0; k <= int'(n); k++) begin
            idx = tail - 4'd1 - 4'(k);
            wr  = (wr_mode == 1'b0) ? 1'b1 : idx[0];
            walk_wr_reg_i = wr;
            walk_arch_i = {1'b0, idx};
            walk_safe_i = {2'b01, idx};
            walk_spec_i = {2'b10, idx};
            exp_rv = (k != int'(n)) && wr;
            #2;
            chk($sformatf("%s_idx%0d", tag, k), {28'd0, walk_idx_o}, {28'd0, idx});
            chk($sformatf("%s_st%0d", tag, k),
                {24'd0, recovering_o, ren_ready_o, save_ready_o, br_ready_o,
                 mt_rename_valid_o, mt_save_valid_o, mt_restore_valid_o, mt_revert_valid_o},
                {24'd0, 1'b1, 6'd0, exp_rv});
            if (exp_rv)
                chk($sformatf("%s_data%0d", tag, k),
                    {15'd0, mt_revert_arch_o, mt_revert_safe_o, mt_revert_spec_o},
                    {15'd0, 1'b0, idx, 2'b01, idx, 2'b10, idx});
            if (k == rst_at) begin
                nrst_i = 0;
                next_cycle();
                nrst_i = 1;
                save_valid_i = 0; ren_valid_i = 0;
                #2;
                chk({tag, "_after_rst"},
                    {27'd0, recovering_o, mt_revert_valid_o, recover_done_o, ren_ready_o,
                     (ckpt_count_o == 3'd0)},
                    {27'd0, 5'b00011});
                next_cycle();
                idle_inputs();
                return;
            end
            next_cycle();
        end
        save_valid_i = 0; ren_valid_i = 0; walk_wr_reg_i = 0;
        #2;
        chk({tag, "_done"}, {27'd0, recovering_o, recover_done_o, ckpt_count_o}, {27'd0, 2'b01, 3'd0});
        next_cycle();
        #2;
        chk({tag, "_done_clr"}, {31'd0, recover_done_o}, 32'd0);
        next_cycle();
    endtask

    initial begin
        //          ren sav br mis has ok   rdy     mt        st     cnt
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 3'b111, 5'b00000, 2'b00, 3'd0};
        vecs[1]  = '{0, 1, 0, 0, 0, 0, 3'b011, 5'b01000, 2'b00, 3'd0};
        vecs[2]  = '{0, 1, 0, 0, 0, 0, 3'b011, 5'b01000, 2'b00, 3'd1};
        vecs[3]  = '{0, 1, 0, 0, 0, 0, 3'b011, 5'b01000, 2'b00, 3'd2};
        vecs[4]  = '{0, 1, 0, 0, 0, 0, 3'b001, 5'b00000, 2'b00, 3'd3};
        vecs[5]  = '{1, 0, 0, 0, 0, 0, 3'b101, 5'b10000, 2'b00, 3'd3};
        vecs[6]  = '{0, 1, 1, 0, 1, 1, 3'b001, 5'b00100, 2'b00, 3'd3};
        vecs[7]  = '{0, 1, 1, 0, 1, 1, 3'b011, 5'b01100, 2'b00, 3'd2};
        vecs[8]  = '{1, 0, 1, 0, 1, 1, 3'b111, 5'b10100, 2'b00, 3'd2};
        vecs[9]  = '{1, 1, 1, 1, 1, 1, 3'b001, 5'b00110, 2'b00, 3'd1};
        vecs[10] = '{0, 0, 0, 0, 0, 0, 3'b111, 5'b00000, 2'b01, 3'd0};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 3'b111, 5'b00000, 2'b00, 3'd0};
        vecs[12] = '{1, 0, 1, 0, 0, 1, 3'b111, 5'b10000, 2'b00, 3'd0};
        vecs[13] = '{0, 0, 1, 0, 1, 1, 3'b111, 5'b00100, 2'b00, 3'd0};
        vecs[14] = '{0, 0, 0, 0, 0, 0, 3'b111, 5'b00000, 2'b00, 3'd0};
        vecs[15] = '{0, 1, 0, 0, 0, 0, 3'b011, 5'b01000, 2'b00, 3'd0};
        vecs[16] = '{0, 0, 1, 0, 1, 0, 3'b111, 5'b00100, 2'b00, 3'd1};
        vecs[17] = '{0, 0, 0, 0, 0, 0, 3'b111, 5'b00000, 2'b00, 3'd1};

        nrst_i = 0;
        idle_inputs();
        ren_arch_i = 5'd7; ren_phys_i = 6'd33; save_rob_i = 4'd0;
        br_rob_i = 4'd2; br_col_i = 2'd1; rob_tail_i = 4'd0;
        walk_arch_i = '0; walk_safe_i = '0; walk_spec_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        nrst_i = 1;

        for (int i = 0; i < 18; i++) begin
            ren_valid_i = vecs[i].ren_v; save_valid_i = vecs[i].save_v;
            br_valid_i = vecs[i].br_v; br_mispred_i = vecs[i].mis;
            br_has_ckpt_i = vecs[i].has; mt_restore_ok_i = vecs[i].ok;
            save_rob_i = 4'(i);
            br_rob_i = 4'd2; br_col_i = 2'd1;
            #2;
            chk($sformatf("vec%0d", i), {19'd0, out_pack()},
                {19'd0, vecs[i].rdy, vecs[i].mt, vecs[i].st, vecs[i].cnt});
            if (vecs[i].mt[2])
                chk($sformatf("vec%0d_rs_tag", i), {26'd0, mt_restore_rob_o, mt_restore_col_o},
                    {26'd0, 4'd2, 2'd1});
            if (vecs[i].mt[3])
                chk($sformatf("vec%0d_save_rob", i), {28'd0, mt_save_rob_o}, {28'd0, 4'(i)});
            if (vecs[i].mt[4])
                chk($sformatf("vec%0d_ren_tag", i), {21'd0, mt_rename_arch_o, mt_rename_phys_o},
                    {21'd0, 5'd7, 6'd33});
            next_cycle();
        end
        idle_inputs();
        #2;
        chk("pre_walk_cnt", {29'd0, ckpt_count_o}, 32'd1);
        next_cycle();

        do_walk("walk_basic", 4'd9, 4'd5, 1'b1, 1'b0, -1);
        do_walk("walk_wrap", 4'd1, 4'd14, 1'b0, 1'b1, -1);
        do_walk("walk_one", 4'd4, 4'd3, 1'b0, 1'b0, -1);
        do_walk("walk_rst", 4'd12, 4'd2, 1'b0, 1'b0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
